// File: rtl/dvp_tx_pkg.sv
// -----------------------------------------------------------------------------
// dvp_tx_pkg
// Shared types and constants for the DVP camera pattern transmitter:
//   state_t    - frame sequencer states
//   pattern_t  - test pattern selector (matches the 2-bit i_pattern encoding)
//   BAR_COLORS - RGB565 colours of the 8-bar pattern, left to right
// -----------------------------------------------------------------------------
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  typedef enum logic [1:0] {
    BAR   = 2'd0,
    RAMP  = 2'd1,
    SOLID = 2'd2,
    CHECK = 2'd3
  } pattern_t;

  // Index 0 is the leftmost bar.
  localparam logic [0:7][15:0] BAR_COLORS = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/dvp_pattern_gen.sv
// -----------------------------------------------------------------------------
// dvp_pattern_gen
// Purely combinational pixel source: maps a pixel coordinate to an RGB565 value.
// Ports:
//   pattern   - selected test pattern (latched per frame by the caller)
//   x, y      - pixel column / active line index
//   color     - fixed colour used by the SOLID pattern
//   frame_lsb - frame counter LSB; flips the checkerboard phase every frame
//   pixel     - 16-bit RGB565 result
// -----------------------------------------------------------------------------
module dvp_pattern_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  pattern_t    pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] color,
  input  logic        frame_lsb,
  output logic [15:0] pixel
);

  // Narrow frames still get 8 bars, one pixel wide each.
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [15:0] bar_full;
  logic [2:0]  bar_idx;
  logic        check_on;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    bar_full = x / 16'(BAR_W);
    // Pixels past the 8th full bar (width remainder) stay in the last bar.
    bar_idx  = (bar_full > 16'd7) ? 3'd7 : bar_full[2:0];
    // 8x8 tiles: parity of bit 3 of x and y, inverted on odd frames.
    check_on = ((((x ^ y) >> 3) & 16'h0001) != 16'h0000) ^ frame_lsb;
    pixel    = 16'h0000;
    case (pattern)
      BAR:     pixel = BAR_COLORS[bar_idx];
      RAMP:    pixel = x;
      SOLID:   pixel = color;
      CHECK:   pixel = check_on ? 16'hFFFF : 16'h0000;
      default: pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// -----------------------------------------------------------------------------
// dvp_pattern_tx
// Emulates a DVP camera sensor: generates pclk at half the system clock and a
// vsync/href/data byte stream carrying a selectable RGB565 test pattern.
// Ports:
//   i_sys_clk, i_sys_rst_n - system clock, async active-low reset
//   i_enable               - run frames back to back while high
//   i_pattern, i_color     - pattern select / solid colour (latched per frame)
//   o_cam_pclk             - emulated pixel clock (toggles every i_sys_clk)
//   o_cam_vsync, o_cam_href, o_cam_data - DVP frame sync, line valid, bytes
//   o_frame_done           - one i_sys_clk pulse at the end of each frame
//   o_frame_cnt            - completed frame count (wraps)
// All DVP outputs change only when pclk falls, so they are stable at its rise.
// -----------------------------------------------------------------------------
module dvp_pattern_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_color,
  output logic        o_cam_pclk,
  output logic        o_cam_vsync,
  output logic        o_cam_href,
  output logic [7:0]  o_cam_data,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  localparam int LINE      = 2 * H_ACTIVE + H_BLANK;
  localparam int ACT_TICKS = 2 * H_ACTIVE;
  localparam int MAX_A     = (VS_LINES > V_BACK)  ? VS_LINES : V_BACK;
  localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW        = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  state_t        state, state_next;
  logic [CW-1:0] col, col_next;    // tick within the current line
  logic [LW-1:0] line, line_next;  // line within the current phase
  logic          phase_last, start, frame_end;
  logic          tick, href_next;
  pattern_t      pat_q;
  logic [15:0]   color_q, pixel;
  logic [7:0]    byte_next;

  // A tick is the system cycle whose edge drives pclk low.
  assign tick = o_cam_pclk;

  always_comb begin
    state_next = state;
    col_next   = col;
    line_next  = line;
    start      = 1'b0;
    frame_end  = 1'b0;
    case (state)
      VSYNC:   phase_last = (line == LW'(VS_LINES - 1));
      VBACK:   phase_last = (line == LW'(V_BACK - 1));
      ACTIVE:  phase_last = (line == LW'(V_ACTIVE - 1));
      VFRONT:  phase_last = (line == LW'(V_FRONT - 1));
      default: phase_last = 1'b0;
    endcase
    if (tick) begin
      if (state == IDLE) begin
        if (i_enable) begin
          state_next = VSYNC;
          col_next   = '0;
          line_next  = '0;
          start      = 1'b1;
        end
      end else if (col == CW'(LINE - 1)) begin
        col_next = '0;
        if (phase_last) begin
          line_next = '0;
          case (state)
            VSYNC:  state_next = VBACK;
            VBACK:  state_next = ACTIVE;
            ACTIVE: state_next = VFRONT;
            VFRONT: begin
              frame_end = 1'b1;
              // Enable is only sampled here, so dropping it never cuts a frame.
              if (i_enable) begin
                state_next = VSYNC;
                start      = 1'b1;
              end else begin
                state_next = IDLE;
              end
            end
            default: state_next = IDLE;
          endcase
        end else begin
          line_next = line + LW'(1);
        end
      end else begin
        col_next = col + CW'(1);
      end
    end
  end

  // Outputs are registered from the next-state values, so they line up with
  // the state/counters they describe.
  assign href_next = (state_next == ACTIVE) && (32'(col_next) < ACT_TICKS);
  assign byte_next = col_next[0] ? pixel[7:0] : pixel[15:8];

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_gen (
    .pattern   (pat_q),
    .x         (16'(col_next >> 1)),
    .y         (16'(line_next)),
    .color     (color_q),
    .frame_lsb (o_frame_cnt[0]),
    .pixel     (pixel)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state <= IDLE;
      col   <= '0;
      line  <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      line  <= line_next;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      o_cam_pclk   <= 1'b0;
      o_cam_vsync  <= 1'b0;
      o_cam_href   <= 1'b0;
      o_cam_data   <= 8'h00;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= 16'h0000;
      pat_q        <= BAR;
      color_q      <= 16'h0000;
    end else begin
      o_cam_pclk   <= ~o_cam_pclk;
      o_frame_done <= 1'b0;
      if (tick) begin
        o_cam_vsync <= (state_next == VSYNC);
        o_cam_href  <= href_next;
        o_cam_data  <= href_next ? byte_next : 8'h00;
        if (start) begin
          pat_q   <= pattern_t'(i_pattern);
          color_q <= i_color;
        end
        if (frame_end) begin
          o_frame_done <= 1'b1;
          o_frame_cnt  <= o_frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_dvp_pattern_tx
// Self-checking bench for dvp_pattern_tx with a small frame geometry
// (LINE = 20 ticks, frame = 140 ticks). A frame-position model predicts every
// output on every cycle; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_dvp_pattern_tx;

  localparam int HA    = 8;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int VSL   = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = (VSL + VB + VA + VF) * LINE;
  localparam int ACT0  = (VSL + VB) * LINE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pat = 2'd0;
  logic [15:0] color = 16'h0000;
  logic        pclk, vsync, href, fd;
  logic [7:0]  data;
  logic [15:0] fcnt;

  dvp_pattern_tx #(
    .H_ACTIVE (HA), .V_ACTIVE (VA), .H_BLANK (HB),
    .VS_LINES (VSL), .V_BACK (VB), .V_FRONT (VF)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_enable     (en),
    .i_pattern    (pat),
    .i_color      (color),
    .o_cam_pclk   (pclk),
    .o_cam_vsync  (vsync),
    .o_cam_href   (href),
    .o_cam_data   (data),
    .o_frame_done (fd),
    .o_frame_cnt  (fcnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame-position model ----------------
  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic        m_pclk, m_run, m_fd;
  int          m_t, m_frames;
  logic [1:0]  m_pat;
  logic [15:0] m_color;
  logic [15:0] m_cnt_base = 16'h0000;  // preload offset applied by the stimulus

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pclk = 1'b0; m_run = 1'b0; m_fd = 1'b0; m_t = 0; m_frames = 0;
    end else begin
      m_fd = 1'b0;
      if (m_pclk) begin
        if (m_run) begin
          m_t++;
          if (m_t == FRAME) begin
            m_fd = 1'b1;
            m_frames++;
            m_run = 1'b0;
          end
        end
        if (!m_run && en) begin
          m_run = 1'b1; m_t = 0; m_pat = pat; m_color = color;
        end
      end
      m_pclk = ~m_pclk;
    end
  end

  function automatic logic [15:0] m_pixel(input int x, input int y, input logic lsb);
    int b;
    b = x / (HA / 8);
    if (b > 7) b = 7;
    case (m_pat)
      2'd0:    return bar_tab[b];
      2'd1:    return 16'(x);
      2'd2:    return m_color;
      default: return ((((x / 8) % 2) != ((y / 8) % 2)) != lsb) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // ---------------- compare + recorder ----------------
  int         cyc = 0, tick_no = 0;
  logic       vs_prev = 1'b0, hr_prev = 1'b0;
  int         vs_rise_q[$], href_rise_q[$], fd_q[$];
  logic [7:0] byte_q[$];
  logic [15:0] cnt_q[$];

  always @(negedge clk) begin : cmp
    logic vs, hr;
    logic [7:0] b;
    logic [15:0] px, ec;
    int a, c;
    ec = m_cnt_base + 16'(m_frames);
    vs = 1'b0; hr = 1'b0; b = 8'h00;
    if (m_run) begin
      vs = (m_t < VSL * LINE);
      a  = m_t - ACT0;
      if (a >= 0 && a < VA * LINE) begin
        c = a % LINE;
        if (c < 2 * HA) begin
          hr = 1'b1;
          px = m_pixel(c / 2, a / LINE, ec[0]);
          b  = (c % 2 == 0) ? px[15:8] : px[7:0];
        end
      end
    end
    check("cycle", {4'b0, pclk, vsync, href, data, fd, fcnt},
                   {4'b0, m_pclk, vs, hr, b, m_fd, ec});
    cyc++;
    if (!rst_n) begin
      vs_prev = 1'b0; hr_prev = 1'b0;
    end else if (!pclk) begin
      tick_no++;
      if (vsync && !vs_prev) vs_rise_q.push_back(tick_no);
      if (href && !hr_prev)  href_rise_q.push_back(tick_no);
      if (href) byte_q.push_back(data);
      vs_prev = vsync; hr_prev = href;
    end
    if (fd) begin
      fd_q.push_back(cyc);
      cnt_q.push_back(fcnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int start, k;
    start = fd_q.size();
    k = 0;
    while (fd_q.size() < start + n && k < budget) begin
      step(1);
      k++;
    end
    check("wait_frame_done", fd_q.size(), start + n);
  endtask

  logic [7:0] exp_line0 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  initial begin
    int n, k;
    logic p;
    // Reset state
    step(3);
    check("reset_outputs", {pclk, vsync, href, data, fd, fcnt}, 0);
    en = 1'b1; pat = 2'd0;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_edge1", {pclk, vsync}, 2'b10);
    @(negedge clk);
    check("release_edge2", {pclk, vsync}, 2'b01);
    #1;

    // Colour bars, three back-to-back frames
    wait_frames(1, 400);
    check("bytes_frame1", byte_q.size(), 4 * 2 * HA);
    for (int i = 0; i < 16; i++) check($sformatf("bar_byte%0d", i), byte_q[i], exp_line0[i]);
    check("href_after_vsync", href_rise_q[0] - vs_rise_q[0], ACT0);
    check("href_pulses", href_rise_q.size(), VA);
    check("href_spacing", href_rise_q[1] - href_rise_q[0], LINE);
    wait_frames(2, 700);
    check("fd_gap1", fd_q[1] - fd_q[0], 2 * FRAME);
    check("fd_gap2", fd_q[2] - fd_q[1], 2 * FRAME);
    check("cnt1", cnt_q[0], 16'd1);
    check("cnt2", cnt_q[1], 16'd2);
    check("cnt3", cnt_q[2], 16'd3);
    check("vsync_period", vs_rise_q[1] - vs_rise_q[0], FRAME);

    // Solid colour latched per frame
    pat = 2'd2; color = 16'h1234;
    wait_frames(1, 400);
    byte_q.delete();
    step(120);
    color = 16'hABCD;
    wait_frames(1, 400);
    check("solid_size", byte_q.size(), 4 * 2 * HA);
    check("solid_b0", byte_q[0], 8'h12);
    check("solid_b1", byte_q[1], 8'h34);
    check("solid_b62", byte_q[62], 8'h12);
    check("solid_b63", byte_q[63], 8'h34);
    byte_q.delete();
    wait_frames(1, 400);
    check("solid_new_b0", byte_q[0], 8'hAB);
    check("solid_new_b1", byte_q[1], 8'hCD);

    // Drop enable during active line 2
    step(2 * (ACT0 + LINE + 5));
    en = 1'b0;
    wait_frames(1, 400);
    check("cnt7", cnt_q[cnt_q.size() - 1], 16'd7);
    n = fd_q.size();
    step(100);
    check("idle_no_fd", fd_q.size(), n);
    check("idle_outputs", {vsync, href, data}, 0);
    p = pclk;
    step(1);
    check("idle_pclk_toggles", pclk ^ p, 1);

    // Reset in the middle of ACTIVE
    en = 1'b1;
    k = 0;
    while (!href && k < 400) begin
      step(1);
      k++;
    end
    check("href_before_reset", href, 1'b1);
    n = fd_q.size();
    rst_n = 1'b0; pat = 2'd3; m_cnt_base = 16'h0000;
    #1;
    check("reset_same_cycle", {pclk, vsync, href, data, fd, fcnt}, 0);
    step(3);
    check("reset_no_fd", fd_q.size(), n);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_edge1", {pclk, vsync}, 2'b10);
    @(negedge clk);
    check("rerelease_edge2", {pclk, vsync}, 2'b01);
    #1;

    // Counter wrap and checker phase
    force dut.o_frame_cnt = 16'hFFFF;
    m_cnt_base = 16'hFFFF;
    byte_q.delete();
    step(1);
    release dut.o_frame_cnt;
    wait_frames(1, 400);
    check("cnt_wrap", cnt_q[cnt_q.size() - 1], 16'h0000);
    check("check_odd_size", byte_q.size(), 4 * 2 * HA);
    check("check_odd_b0", byte_q[0], 8'hFF);
    byte_q.delete();
    en = 1'b0;
    wait_frames(1, 400);
    check("check_even_size", byte_q.size(), 4 * 2 * HA);
    check("check_even_b0", byte_q[0], 8'h00);
    check("cnt_after_wrap", fcnt, 16'h0001);
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/dvp_pattern_tx.md
DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

Interface
REQ-001 SHALL have parameters: H_ACTIVE, default 640, active pixels per line; V_ACTIVE, default 480, active lines per frame; H_BLANK, default 144, pclk periods with href low per line; VS_LINES, default 4, vsync lines; V_BACK, default 16, lines after vsync; V_FRONT, default 4, lines after active.
REQ-002 SHALL have ports: i_sys_clk, in, 1, single clock; i_sys_rst_n, in, 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_enable, in, 1, run frames; i_pattern, in, 2, pattern select; i_color, in, 16, fixed RGB565 colour.
REQ-004 SHALL have ports: o_cam_pclk, out, 1, emulated pixel clock; o_cam_vsync, out, 1, active-high frame sync; o_cam_href, out, 1, line valid; o_cam_data, out, 8, byte stream.
REQ-005 SHALL have ports: o_frame_done, out, 1, one-cycle pulse at frame end; o_frame_cnt, out, 16, completed frames.

Function
REQ-006 SHALL toggle o_cam_pclk on every i_sys_clk edge after reset, in all states, including IDLE.
REQ-007 SHALL update vsync, href, data and counters only on tick cycles, where o_cam_pclk is 1 and falls next, so outputs are stable at the pclk rising edge.
REQ-008 SHALL implement the FSM IDLE->VSYNC->VBACK->ACTIVE->VFRONT, each line lasting LINE = 2*H_ACTIVE+H_BLANK ticks.
REQ-009 IDLE: SHALL leave IDLE on the first tick with i_enable=1, making o_cam_vsync 1 at that tick.
REQ-010 VSYNC: SHALL hold o_cam_vsync high for VS_LINES*LINE ticks, then go to VBACK.
REQ-011 VBACK: SHALL last V_BACK*LINE ticks with vsync and href low.
REQ-012 ACTIVE: per line, SHALL hold href high for 2*H_ACTIVE ticks, then low for H_BLANK ticks; after V_ACTIVE lines, go to VFRONT.
REQ-013 VFRONT: SHALL last V_FRONT*LINE ticks, pulse o_frame_done for one i_sys_clk cycle on its last tick, and increment o_frame_cnt, wrapping FFFF->0000.
REQ-014 After VFRONT, SHALL go to VSYNC if i_enable=1, else IDLE.
REQ-015 Deasserting i_enable mid-frame SHALL NOT truncate the frame.
REQ-016 SHALL output each pixel as two bytes, pixel[15:8] first, then pixel[7:0]; x = pixel index 0..H_ACTIVE-1, y = active line 0..V_ACTIVE-1.
REQ-017 SHALL drive o_cam_data = 8'h00 whenever href is 0.
REQ-018 SHALL latch i_pattern and i_color on VSYNC entry and hold them for the whole frame.
REQ-019 Pattern 0 (colour bar): 8 bars of width H_ACTIVE/8: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; the last bar absorbs the remainder.
REQ-020 Pattern 1 (ramp): pixel = x[15:0], zero-extended or truncated.
REQ-021 Pattern 2: pixel = latched i_color.
REQ-022 Pattern 3 (checker): pixel = FFFF if x[3]^y[3]^o_frame_cnt[0], else 0000.
REQ-023 Counters SHALL be sized with $clog2 of their maximum and compare with full width, with no truncation at LINE or frame boundaries.

Reset
REQ-024 While i_sys_rst_n=0, SHALL force state IDLE, o_cam_pclk=0, vsync=0, href=0, data=00, o_frame_done=0, o_frame_cnt=0, and all counters to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, without completing it or pulsing o_frame_done.
REQ-026 After release, the first tick SHALL occur on the second i_sys_clk edge.

Structure
REQ-027 Package dvp_tx_pkg SHALL hold the state enum, the pattern enum (BAR, RAMP, SOLID, CHECK) and the 8-entry colour-bar constant array.
REQ-028 Sub-module dvp_pattern_gen SHALL be combinational: (pattern, x, y, color, frame_lsb) -> 16-bit pixel; the top SHALL hold the FSM, counters and byte mux.

Verification (bench params H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1; LINE=20, frame=140 ticks)
REQ-029 Hold i_enable=1, pattern 0 -> vsync high 20 ticks; first href 40 ticks after vsync rise; 4 href pulses of 16 ticks; byte stream FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
REQ-030 Three back-to-back frames -> o_frame_done pulses 280 sys clocks apart; o_frame_cnt = 1, 2, 3; no idle gap between VFRONT and VSYNC.
REQ-031 Pattern 2, i_color=1234, i_color changed to ABCD mid-frame -> all active bytes 12,34 until the next frame, then AB,CD.
REQ-032 Drop i_enable during line 2 of ACTIVE -> frame completes, frame_done pulses once, IDLE holds vsync/href/data low while pclk keeps toggling.
REQ-033 Assert reset during ACTIVE -> all outputs at reset values within the same cycle, no frame_done, o_frame_cnt=0; after release with i_enable=1, a clean frame starts at the first tick.
REQ-034 Preload o_frame_cnt=FFFF via force, then complete a frame -> o_frame_cnt=0000, and pattern 3 checker phase inverts on the next frame.
